mem_lsu: RTL and testbench

//  MEM-stage load/store unit. Consumes the EX/MEM register outputs (waddr/we/wdata/aluop/addr/reg2).

---
 rtl/mem_lsu_pkg.sv | 31 +++
 rtl/mem_lsu_if.sv | 24 ++
 rtl/mem_lsu_lane.sv | 94 +++++++++
 rtl/mem_lsu.sv | 157 +++++++++++++++
 tb/tb_mem_lsu.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// rtl/mem_lsu_pkg.sv - shared op codes, FSM state codes and size type for the MEM-stage LSU
//
// Purpose: single source of the memory op codes and LSU state encodings used by
//          mem_lsu, mem_lsu_lane and the bench.
// Ports:   none (package).

package mem_lsu_pkg;

  // EX/MEM op codes (aluop). NOP_OP means the stage is idle.
  localparam logic [4:0] NOP_OP = 5'h00;
  localparam logic [4:0] LB_OP  = 5'h10;
  localparam logic [4:0] LBU_OP = 5'h11;
  localparam logic [4:0] LH_OP  = 5'h12;
  localparam logic [4:0] LHU_OP = 5'h13;
  localparam logic [4:0] LW_OP  = 5'h14;
  localparam logic [4:0] SB_OP  = 5'h18;
  localparam logic [4:0] SH_OP  = 5'h19;
  localparam logic [4:0] SW_OP  = 5'h1A;

  // LSU FSM state codes
  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_BUSY = 2'd1;
  localparam logic [1:0] LSU_DONE = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

endpackage

// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - data-bus req/ack interface between the LSU and memory
//
// Purpose: groups the data-bus transaction signals.
// Signals: req   - request, held until ack
//          we    - 1 = store
//          addr  - word address {addr[31:2],2'b00}
//          sel   - byte-lane enables
//          wdata - lane-replicated store data
//          ack   - transaction complete, rdata valid in the same cycle
//          rdata - read word
// Modports: master (LSU side), slave (memory side).

interface mem_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lsu_lane.sv
// rtl/mem_lsu_lane.sv - combinational byte-lane logic for the LSU
//
// Purpose: decodes the memory op, builds byte-lane selects and replicated store
//          data, flags misaligned accesses and extracts/extends load data.
// Ports:   aluop    in  5   op code
//          addr_lo  in  2   byte offset addr[1:0]
//          reg2     in  32  store data
//          rdata    in  32  read word from the bus
//          is_mem   out 1   op is a load or store
//          is_load  out 1   op is a load
//          is_store out 1   op is a store
//          misalign out 1   memory op with misaligned offset
//          sel      out 4   byte-lane enables
//          wdata    out 32  lane-replicated store data
//          ld_data  out 32  aligned, extended load result

module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [4:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] reg2,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_load,
  output logic        is_store,
  output logic        misalign,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  mem_size_e   size;
  logic        sext;
  logic        mis_raw;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    size     = SZ_WORD;
    sext     = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    case (aluop)
      LB_OP:  begin is_load  = 1'b1; size = SZ_BYTE; sext = 1'b1; end
      LBU_OP: begin is_load  = 1'b1; size = SZ_BYTE; end
      LH_OP:  begin is_load  = 1'b1; size = SZ_HALF; sext = 1'b1; end
      LHU_OP: begin is_load  = 1'b1; size = SZ_HALF; end
      LW_OP:  begin is_load  = 1'b1; end
      SB_OP:  begin is_store = 1'b1; size = SZ_BYTE; end
      SH_OP:  begin is_store = 1'b1; size = SZ_HALF; end
      SW_OP:  begin is_store = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    sel     = 4'b1111;
    wdata   = reg2;
    mis_raw = |addr_lo;
    ld_data = rdata;
    case (size)
      SZ_BYTE: begin
        sel     = 4'b0001 << addr_lo;
        wdata   = {4{reg2[7:0]}};
        mis_raw = 1'b0;
        ld_data = {{24{sext & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        sel     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{reg2[15:0]}};
        mis_raw = addr_lo[0];
        ld_data = {{16{sext & half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

  // Non-memory ops decode as word size; never flag them.
  assign misalign = is_mem & mis_raw;

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit with req/ack data bus and pipeline stall
//
// Purpose: runs one bus transaction per aligned load/store (IDLE -> BUSY -> DONE),
//          stalls the pipeline while it is outstanding, and drives the MEM/WB
//          write-back fields. Non-memory ops pass through combinationally.
// Ports:   clk          in   1   clock, rising edge
//          rst          in   1   asynchronous active-low reset
//          flush_i      in   1   discard result of the instruction in MEM
//          mem_waddr_i  in   5   dest register from EX/MEM
//          mem_we_i     in   1   reg write enable from EX/MEM
//          mem_wdata_i  in   32  ALU result from EX/MEM
//          mem_aluop_i  in   5   op code from EX/MEM
//          mem_addr_i   in   32  effective byte address
//          mem_reg2_i   in   32  store data
//          dbus         master   data-bus interface
//          wb_waddr_o   out  5   to MEM/WB
//          wb_we_o      out  1   to MEM/WB
//          wb_wdata_o   out  32  to MEM/WB
//          stallreq_o   out  1   stall request
//          misalign_o   out  1   misaligned access flag
//          bus_err_o    out  1   bus timeout pulse
// Parameter: TIMEOUT - BUSY cycles before a bus error; 0 disables the timeout.

module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [4:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  mem_lsu_if.master   dbus,
  output logic [4:0]  wb_waddr_o,
  output logic        wb_we_o,
  output logic [31:0] wb_wdata_o,
  output logic        stallreq_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int       CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit       TMO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       sel_q;
  logic [31:0]      wdata_q;
  logic [31:0]      ld_q;
  logic             discard_q;
  logic [CNT_W-1:0] tmo_cnt;

  logic        is_mem;
  logic        is_load;
  logic        is_store;
  logic        mis;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ld;
  logic        start;
  logic        timeout_hit;

  mem_lsu_lane u_lane (
    .aluop    (mem_aluop_i),
    .addr_lo  (mem_addr_i[1:0]),
    .reg2     (mem_reg2_i),
    .rdata    (dbus.rdata),
    .is_mem   (is_mem),
    .is_load  (is_load),
    .is_store (is_store),
    .misalign (mis),
    .sel      (lane_sel),
    .wdata    (lane_wdata),
    .ld_data  (lane_ld)
  );

  assign start = (state == LSU_IDLE) && is_mem && !mis && !flush_i;

  // Fires in the last allowed BUSY cycle when ack has not arrived; ack wins a tie.
  assign timeout_hit = TMO_EN && (state == LSU_BUSY) && !dbus.ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LSU_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      ld_q      <= '0;
      discard_q <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (start) begin
            req_q     <= 1'b1;
            we_q      <= is_store;
            addr_q    <= {mem_addr_i[31:2], 2'b00};
            sel_q     <= lane_sel;
            wdata_q   <= lane_wdata;
            discard_q <= 1'b0;
            tmo_cnt   <= '0;
            state     <= LSU_BUSY;
          end
        end
        LSU_BUSY: begin
          // A flush cannot abort the bus cycle; remember to drop the result.
          if (flush_i) discard_q <= 1'b1;
          if (dbus.ack) begin
            req_q <= 1'b0;
            ld_q  <= lane_ld;
            state <= LSU_DONE;
          end else if (timeout_hit) begin
            req_q     <= 1'b0;
            discard_q <= 1'b1;
            state     <= LSU_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        LSU_DONE: state <= LSU_IDLE;
        default:  state <= LSU_IDLE;
      endcase
    end
  end

  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.sel   = sel_q;
  assign dbus.wdata = wdata_q;

  assign stallreq_o = start || (state == LSU_BUSY);
  assign bus_err_o  = timeout_hit;
  assign misalign_o = (state == LSU_IDLE) && is_mem && mis;
  assign wb_waddr_o = mem_waddr_i;
  assign wb_wdata_o = (state == LSU_DONE) ? ld_q : mem_wdata_i;

  always_comb begin
    wb_we_o = 1'b0;
    case (state)
      LSU_IDLE: wb_we_o = mem_we_i && !is_mem && !flush_i;
      LSU_DONE: wb_we_o = mem_we_i && is_load && !discard_q && !flush_i;
      default:  wb_we_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - scoreboard testbench for mem_lsu

module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam logic [4:0] ALU_OP = 5'h05;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  waddr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [4:0]  aluop = NOP_OP;
  logic [31:0] addr = '0;
  logic [31:0] reg2 = '0;

  logic [4:0]  wb_waddr;
  logic        wb_we;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic        misalign;
  logic        bus_err;

  mem_lsu_if dbus ();

  mem_lsu #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .mem_waddr_i (waddr),
    .mem_we_i    (we),
    .mem_wdata_i (wdata),
    .mem_aluop_i (aluop),
    .mem_addr_i  (addr),
    .mem_reg2_i  (reg2),
    .dbus        (dbus),
    .wb_waddr_o  (wb_waddr),
    .wb_we_o     (wb_we),
    .wb_wdata_o  (wb_wdata),
    .stallreq_o  (stallreq),
    .misalign_o  (misalign),
    .bus_err_o   (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_exp_t;

  wb_exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_ld(input logic [4:0] op);
    return op inside {LB_OP, LBU_OP, LH_OP, LHU_OP, LW_OP};
  endfunction

  function automatic bit is_st(input logic [4:0] op);
    return op inside {SB_OP, SH_OP, SW_OP};
  endfunction

  function automatic logic [3:0] m_sel(input logic [4:0] op, input logic [1:0] a);
    if (op inside {LB_OP, LBU_OP, SB_OP}) return 4'b0001 << a;
    if (op inside {LH_OP, LHU_OP, SH_OP}) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [4:0] op, input logic [31:0] r2);
    if (op == SB_OP) return {4{r2[7:0]}};
    if (op == SH_OP) return {2{r2[15:0]}};
    return r2;
  endfunction

  function automatic logic [31:0] m_load(input logic [4:0] op, input logic [1:0] a,
                                         input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (int'(a) * 8);
    case (op)
      LB_OP:   return {{24{sh[7]}}, sh[7:0]};
      LBU_OP:  return {24'h0, sh[7:0]};
      LH_OP:   return {{16{sh[15]}}, sh[15:0]};
      LHU_OP:  return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  task automatic pop_cmp(input string tag);
    wb_exp_t e;
    check({tag, "_qsize"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_wb_we"}, wb_we, e.we);
      check({tag, "_wb_waddr"}, wb_waddr, e.waddr);
      if (e.we) check({tag, "_wb_wdata"}, wb_wdata, e.wdata);
    end
  endtask

  // ack_at: BUSY cycle (1-based) in which ack is given, 0 = never.
  // flush_at: BUSY cycle in which flush is pulsed, 0 = never.
  task automatic mem_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] r2, input logic [31:0] rd,
                        input int ack_at, input int flush_at);
    wb_exp_t e;
    int busy, reqs, stalls, errs, exp_reqs;
    bit done;
    e.we    = is_ld(op) && (ack_at != 0) && (flush_at == 0);
    e.waddr = 5'd9;
    e.wdata = m_load(op, a[1:0], rd);
    exp_q.push_back(e);
    exp_reqs = (ack_at != 0) ? ack_at : 4;

    @(posedge clk); #1;
    aluop = op; addr = a; reg2 = r2; waddr = 5'd9; we = is_ld(op);
    wdata = 32'h1234_5678; flush = 1'b0; dbus.ack = 1'b0; dbus.rdata = rd;
    #3;
    check({tag, "_idle_req"}, dbus.req, 0);
    check({tag, "_idle_stall"}, stallreq, 1);
    stalls = stallreq ? 1 : 0;
    busy = 0; reqs = 0; errs = 0; done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      busy++;
      dbus.ack = (ack_at != 0) && (busy == ack_at);
      flush = (flush_at != 0) && (busy == flush_at);
      #3;
      if (bus_err) errs++;
      if (dbus.req) begin
        reqs++;
        if (reqs == 1) begin
          check({tag, "_addr"}, dbus.addr, {a[31:2], 2'b00});
          check({tag, "_sel"}, dbus.sel, m_sel(op, a[1:0]));
          check({tag, "_bus_we"}, dbus.we, is_st(op));
          if (is_st(op)) check({tag, "_bus_wdata"}, dbus.wdata, m_wdata(op, r2));
        end
      end
      if (stallreq) stalls++;
      else begin
        done = 1;
        check({tag, "_done_req"}, dbus.req, 0);
        pop_cmp(tag);
      end
    end
    dbus.ack = 1'b0;
    flush = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_req_cycles"}, reqs, exp_reqs);
    check({tag, "_stall_cycles"}, stalls, exp_reqs + 1);
    check({tag, "_bus_err"}, errs, (ack_at == 0) ? 1 : 0);
  endtask

  // Misaligned op, or aligned op flushed in IDLE: no request, no stall, no write-back.
  task automatic no_req_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input bit f, input bit exp_mis);
    wb_exp_t e;
    e.we = 1'b0; e.waddr = 5'd12; e.wdata = '0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    aluop = op; addr = a; reg2 = 32'h5555_AAAA; waddr = 5'd12; we = is_ld(op); flush = f;
    #3;
    check({tag, "_misalign"}, misalign, exp_mis);
    check({tag, "_stall"}, stallreq, 0);
    check({tag, "_req"}, dbus.req, 0);
    pop_cmp(tag);
    @(posedge clk); #1;
    aluop = NOP_OP; flush = 1'b0;
    #3;
    check({tag, "_req_next"}, dbus.req, 0);
  endtask

  // Non-memory op; ack is driven high to show it is ignored outside BUSY.
  task automatic alu_op(input string tag, input logic [4:0] wa, input logic w,
                        input logic [31:0] wd, input bit f);
    wb_exp_t e;
    e.we = w & !f; e.waddr = wa; e.wdata = wd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    aluop = ALU_OP; waddr = wa; we = w; wdata = wd; addr = 32'h0000_0103; flush = f;
    dbus.ack = 1'b1;
    #3;
    pop_cmp(tag);
    if (!f) check({tag, "_wdata"}, wb_wdata, wd);
    check({tag, "_stall"}, stallreq, 0);
    check({tag, "_req"}, dbus.req, 0);
    check({tag, "_misalign"}, misalign, 0);
    @(posedge clk); #1;
    dbus.ack = 1'b0; flush = 1'b0;
    #3;
    check({tag, "_req_next"}, dbus.req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] ops [8];
    logic [4:0] op;
    logic [31:0] a;
    dbus.ack = 1'b0;
    dbus.rdata = '0;

    #2;
    check("rst_req", dbus.req, 0);
    check("rst_bus_we", dbus.we, 0);
    check("rst_sel", dbus.sel, 0);
    check("rst_addr", dbus.addr, 0);
    check("rst_stall", stallreq, 0);
    check("rst_misalign", misalign, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_wb_we", wb_we, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;

    mem_op("sw",  SW_OP,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2, 0);
    mem_op("lb",  LB_OP,  32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1, 0);
    mem_op("lbu", LBU_OP, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1, 0);
    mem_op("lh",  LH_OP,  32'h0000_0102, 32'h0, 32'h8001_7F02, 1, 0);
    mem_op("lhu", LHU_OP, 32'h0000_0100, 32'h0, 32'h1234_F00D, 3, 0);
    mem_op("sb",  SB_OP,  32'h0000_0201, 32'h0000_00A5, 32'h0, 1, 0);
    mem_op("sh",  SH_OP,  32'h0000_0202, 32'h0000_BEEF, 32'h0, 2, 0);
    mem_op("lw",  LW_OP,  32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1, 0);

    no_req_op("mis_lh",  LH_OP, 32'h0000_0101, 1'b0, 1'b1);
    no_req_op("mis_lw",  LW_OP, 32'h0000_0102, 1'b0, 1'b1);
    no_req_op("mis_sh",  SH_OP, 32'h0000_0203, 1'b0, 1'b1);
    no_req_op("mis_sw",  SW_OP, 32'h0000_0301, 1'b0, 1'b1);
    no_req_op("flush_idle", LW_OP, 32'h0000_0400, 1'b1, 1'b0);

    alu_op("alu",       5'd5,  1'b1, 32'd7, 1'b0);
    alu_op("alu_flush", 5'd6,  1'b1, 32'd9, 1'b1);

    mem_op("lw_tmo", LW_OP, 32'h0000_0400, 32'h0, 32'h1111_2222, 0, 0);
    alu_op("alu_after_tmo", 5'd7, 1'b1, 32'h0000_00AB, 1'b0);
    mem_op("lw_flush", LW_OP, 32'h0000_0404, 32'h0, 32'h3333_4444, 3, 1);

    // Reset while a load is outstanding
    @(posedge clk); #1;
    aluop = LW_OP; addr = 32'h0000_0500; waddr = 5'd3; we = 1'b1; dbus.ack = 1'b0;
    @(posedge clk); #3;
    check("rstb_req_busy", dbus.req, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rstb_req_drop", dbus.req, 0);
    aluop = NOP_OP;
    #1;
    check("rstb_stall", stallreq, 0);
    check("rstb_bus_err", bus_err, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    alu_op("alu_after_rst", 5'd8, 1'b1, 32'h0000_0042, 1'b0);

    ops = '{LB_OP, LBU_OP, LH_OP, LHU_OP, LW_OP, SB_OP, SH_OP, SW_OP};
    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 7)];
      a = $urandom;
      if (op inside {LH_OP, LHU_OP, SH_OP}) a[0] = 1'b0;
      if (op inside {LW_OP, SW_OP}) a[1:0] = 2'b00;
      mem_op($sformatf("rnd%0d", i), op, a, $urandom, $urandom, $urandom_range(1, 3), 0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
